// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: request handshake, floor tracking,
// travel/door timing and error freeze/resume with alarm.
module elevator_car_ctrl #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic               i_fsm_clock,
    input  logic               i_fsm_reset,
    input  logic               i_req_valid,
    input  logic [FLOOR_W-1:0] i_req_floor,
    output logic               o_req_ready,
    input  logic               i_fsm_error_flag,
    input  logic               i_fsm_error_clear,
    output logic               o_fsm_move_up,
    output logic               o_fsm_move_down,
    output logic               o_fsm_open_door,
    output logic               o_fsm_alarm,
    output logic               o_req_err,
    output logic [FLOOR_W-1:0] o_cur_floor
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    state_t             saved_q, saved_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               req_err_q, req_err_d;
    logic               up_q, down_q, door_q, alarm_q;
    logic               ready;
    logic               accept;
    logic               tdone;
    logic               ddone;
    logic               oor;
    logic [FLOOR_W-1:0] floor_up;
    logic [FLOOR_W-1:0] floor_dn;

    assign ready    = (state_q == S_IDLE) & ~i_fsm_error_flag;
    assign accept   = i_req_valid & ready;
    assign tdone    = tcnt_q == TW'(TRAVEL_CYCLES - 1);
    assign ddone    = dcnt_q == DW'(DOOR_CYCLES - 1);
    assign oor      = {1'b0, i_req_floor} >= (FLOOR_W + 1)'(FLOORS);
    assign floor_up = floor_q + 1'b1;
    assign floor_dn = floor_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        floor_d   = floor_q;
        target_d  = target_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        req_err_d = 1'b0;
        // Error entry wins over acceptance and counter terminal events
        if (state_q != S_ERR && i_fsm_error_flag) begin
            state_d = S_ERR;
            saved_d = state_q;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        target_d = i_req_floor;
                        tcnt_d   = '0;
                        dcnt_d   = '0;
                        if (oor) begin
                            req_err_d = 1'b1;
                        end else if (i_req_floor == floor_q) begin
                            state_d = S_DOOR;
                        end else if (i_req_floor > floor_q) begin
                            state_d = S_UP;
                        end else begin
                            state_d = S_DOWN;
                        end
                    end
                end
                S_UP: begin
                    if (tdone) begin
                        tcnt_d  = '0;
                        floor_d = floor_up;
                        if (floor_up == target_q) begin
                            state_d = S_DOOR;
                            dcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (tdone) begin
                        tcnt_d  = '0;
                        floor_d = floor_dn;
                        if (floor_dn == target_q) begin
                            state_d = S_DOOR;
                            dcnt_d  = '0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_DOOR: begin
                    if (ddone) begin
                        state_d = S_IDLE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                S_ERR: begin
                    if (i_fsm_error_clear && !i_fsm_error_flag) begin
                        state_d = saved_q;
                        dcnt_d  = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_fsm_clock) begin
        if (i_fsm_reset) begin
            state_q   <= S_IDLE;
            saved_q   <= S_IDLE;
            floor_q   <= '0;
            target_q  <= '0;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
            req_err_q <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            door_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            floor_q   <= floor_d;
            target_q  <= target_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
            req_err_q <= req_err_d;
            up_q      <= state_d == S_UP;
            down_q    <= state_d == S_DOWN;
            door_q    <= state_d == S_DOOR;
            alarm_q   <= state_d == S_ERR;
        end
    end

    assign o_req_ready     = ready;
    assign o_fsm_move_up   = up_q;
    assign o_fsm_move_down = down_q;
    assign o_fsm_open_door = door_q;
    assign o_fsm_alarm     = alarm_q;
    assign o_req_err       = req_err_q;
    assign o_cur_floor     = floor_q;

endmodule
